// File: rtl/cpu_pkg.sv
// Shared core-wide constants and helpers for the fetch front end.
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/sync_fifo_flush.sv
// Synchronous FIFO with wrap-around pointers, occupancy counter and a synchronous flush.
module sync_fifo_flush #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [LvlW-1:0]  level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      wptr_d = wptr_q + PtrW'(do_push);
      rptr_d = rptr_q + PtrW'(do_pop);
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction fetch front end: fetch-PC generator feeding a prefetch queue towards decode.
module instr_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instr_mem_ready_i,
  input  logic [DATA_W-1:0]        instr_mem_data_i,
  output logic [ADDR_W-1:0]        instr_mem_addr_o,
  output logic                     instr_mem_rd_o,
  input  logic                     redirect_i,
  input  logic [ADDR_W-1:0]        redirect_addr_i,
  output logic                     instr_valid_o,
  output logic [DATA_W-1:0]        instr_o,
  output logic [ADDR_W-1:0]        instr_addr_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned EntryW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [EntryW-1:0] head;
  logic              fifo_full, fifo_empty;
  logic              accept;

  // Full blocks fetch even when a pop happens this cycle; a redirect kills any stale fetch.
  assign instr_mem_rd_o   = ~fifo_full & ~redirect_i & rst_i;
  assign instr_mem_addr_o = fetch_pc_q;
  assign accept           = instr_mem_rd_o & instr_mem_ready_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_addr_i & ~ADDR_W'(3);
    end else if (accept) begin
      fetch_pc_d = ADDR_W'(next_pc(XLEN'(fetch_pc_q)));
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_q <= RESET_ADDR;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  sync_fifo_flush #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .flush_i (redirect_i),
    .push_i  (accept),
    .data_i  ({fetch_pc_q, instr_mem_data_i}),
    .pop_i   (instr_ready_i),
    .head_o  (head),
    .level_o (level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign instr_valid_o = ~fifo_empty;
  assign instr_addr_o  = head[EntryW-1:DATA_W];
  assign instr_o       = head[DATA_W-1:0];

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed self-checking bench for instr_prefetch_unit with a combinational memory model.
module tb_instr_prefetch_unit;

  logic        clk;
  logic        rst_i;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_ready;
  logic [2:0]  level;

  int n_checks = 0;
  int n_errors = 0;
  int pushes;

  instr_prefetch_unit #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .DEPTH      (4),
    .RESET_ADDR (32'h0)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .instr_mem_ready_i (mem_ready),
    .instr_mem_data_i  (mem_data),
    .instr_mem_addr_o  (mem_addr),
    .instr_mem_rd_o    (mem_rd),
    .redirect_i        (redirect),
    .redirect_addr_i   (redirect_addr),
    .instr_valid_o     (instr_valid),
    .instr_o           (instr),
    .instr_addr_o      (instr_addr),
    .instr_ready_i     (instr_ready),
    .level_o           (level)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign mem_data = word_at(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; mem_ready = 1'b0; redirect = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
    step(); step();
    check("rst_level", 64'(level), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_iaddr", 64'(instr_addr), 64'd0);
    check("rst_rd", 64'(mem_rd), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);

    // 1: streaming with both sides ready
    mem_ready = 1'b1; instr_ready = 1'b1; rst_i = 1'b1;
    #1;
    check("t1_rd0", 64'(mem_rd), 64'd1);
    check("t1_addr0", 64'(mem_addr), 64'd0);
    check("t1_valid0", 64'(instr_valid), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t1_addr", 64'(mem_addr), 64'(4 * k));
      check("t1_valid", 64'(instr_valid), 64'd1);
      check("t1_iaddr", 64'(instr_addr), 64'(4 * (k - 1)));
      check("t1_instr", 64'(instr), 64'(word_at(32'(4 * (k - 1)))));
      check("t1_level", 64'(level), 64'd1);
    end

    // 2: decode stalled, queue fills to DEPTH
    rst_i = 1'b0;
    #1;
    instr_ready = 1'b0; mem_ready = 1'b1; rst_i = 1'b1;
    pushes = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mem_rd && mem_ready) pushes++;
      step();
    end
    check("t2_pushes", 64'(pushes), 64'd4);
    check("t2_level", 64'(level), 64'd4);
    check("t2_rd", 64'(mem_rd), 64'd0);
    check("t2_iaddr", 64'(instr_addr), 64'd0);
    check("t2_addr", 64'(mem_addr), 64'd16);

    // 3: single pop from full, one-cycle refill bubble
    instr_ready = 1'b1;
    #1;
    check("t3_rd_full_pop", 64'(mem_rd), 64'd0);
    check("t3_valid", 64'(instr_valid), 64'd1);
    step();
    instr_ready = 1'b0;
    #1;
    check("t3_level3", 64'(level), 64'd3);
    check("t3_rd_rise", 64'(mem_rd), 64'd1);
    check("t3_addr16", 64'(mem_addr), 64'd16);
    check("t3_head4", 64'(instr_addr), 64'd4);
    step();
    check("t3_level4", 64'(level), 64'd4);
    check("t3_head_hold", 64'(instr_addr), 64'd4);
    mem_ready = 1'b0; instr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("t3_drain_addr", 64'(instr_addr), 64'(4 + 4 * j));
      check("t3_drain_data", 64'(instr), 64'(word_at(32'(4 + 4 * j))));
      step();
    end
    check("t3_empty_valid", 64'(instr_valid), 64'd0);
    check("t3_empty_level", 64'(level), 64'd0);
    instr_ready = 1'b0;

    // 4: redirect with three entries queued
    mem_ready = 1'b1;
    step(); step(); step();
    check("t4_level3", 64'(level), 64'd3);
    redirect = 1'b1; redirect_addr = 32'h103; instr_ready = 1'b1;
    #1;
    check("t4_rd_redir", 64'(mem_rd), 64'd0);
    step();
    redirect = 1'b0;
    #1;
    check("t4_level0", 64'(level), 64'd0);
    check("t4_valid0", 64'(instr_valid), 64'd0);
    check("t4_addr", 64'(mem_addr), 64'h100);
    check("t4_rd", 64'(mem_rd), 64'd1);
    step();
    check("t4_head100", 64'(instr_addr), 64'h100);
    check("t4_data100", 64'(instr), 64'(word_at(32'h100)));
    step();
    check("t4_head104", 64'(instr_addr), 64'h104);
    redirect = 1'b1; redirect_addr = 32'h200;
    step();
    redirect_addr = 32'h307;
    step();
    redirect = 1'b0;
    #1;
    check("t4_b2b_addr", 64'(mem_addr), 64'h304);
    check("t4_b2b_level", 64'(level), 64'd0);

    // 5: memory ready pattern 1,0,0,1
    mem_ready = 1'b0; instr_ready = 1'b0;
    redirect = 1'b1; redirect_addr = 32'h400;
    step();
    redirect = 1'b0; mem_ready = 1'b1; instr_ready = 1'b1;
    #1;
    check("t5_addr_a", 64'(mem_addr), 64'h400);
    step();
    mem_ready = 1'b0;
    #1;
    check("t5_addr_b", 64'(mem_addr), 64'h404);
    check("t5_rd_b", 64'(mem_rd), 64'd1);
    check("t5_head_b", 64'(instr_addr), 64'h400);
    step();
    check("t5_addr_c", 64'(mem_addr), 64'h404);
    check("t5_valid_c", 64'(instr_valid), 64'd0);
    step();
    mem_ready = 1'b1;
    #1;
    check("t5_addr_d", 64'(mem_addr), 64'h404);
    step();
    check("t5_head_e", 64'(instr_addr), 64'h404);
    check("t5_valid_e", 64'(instr_valid), 64'd1);
    check("t5_addr_e", 64'(mem_addr), 64'h408);

    // 6: reset mid-stream near the top of the address space, then a wrap run
    mem_ready = 1'b0; instr_ready = 1'b0;
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0; mem_ready = 1'b1;
    step(); step();
    check("t6_level2", 64'(level), 64'd2);
    check("t6_wrap_addr", 64'(mem_addr), 64'd0);
    check("t6_head", 64'(instr_addr), 64'hFFFF_FFF8);
    rst_i = 1'b0;
    #1;
    check("t6_rst_level", 64'(level), 64'd0);
    check("t6_rst_valid", 64'(instr_valid), 64'd0);
    check("t6_rst_rd", 64'(mem_rd), 64'd0);
    check("t6_rst_addr", 64'(mem_addr), 64'd0);
    check("t6_rst_iaddr", 64'(instr_addr), 64'd0);
    instr_ready = 1'b1;
    step();
    rst_i = 1'b1; redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    #1;
    check("t6_rd_redir", 64'(mem_rd), 64'd0);
    step();
    redirect = 1'b0;
    #1;
    check("t6_addr_top", 64'(mem_addr), 64'hFFFF_FFFC);
    step();
    check("t6_addr_wrap", 64'(mem_addr), 64'd0);
    check("t6_head_top", 64'(instr_addr), 64'hFFFF_FFFC);
    check("t6_data_top", 64'(instr), 64'(word_at(32'hFFFF_FFFC)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
